// File: rtl/lb_key_events_pkg.sv
// Shared definitions for the key-event front end: FSM encoding and board-clock tick default.
package lb_key_events_pkg;

    localparam int unsigned TICK_DIV_DEFAULT = 1000000;
    localparam int unsigned TICK_W_DEFAULT   = 20;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HOLD   = 2'b01,
        REPEAT = 2'b10
    } key_state_e;

endpackage

// File: rtl/lb_key_events_if.sv
// Debounced switch level in, event pulses and held level out.
interface lb_key_events_if;
    logic db_in;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output db_in,
        input  press_pulse, release_pulse, repeat_pulse, held
    );

    modport slave (
        input  db_in,
        output press_pulse, release_pulse, repeat_pulse, held
    );
endinterface

// File: rtl/lb_key_events_tick_gen.sv
// lb_tick_gen: free-running prescaler 0..TICK_DIV-1 with synchronous clear; tick on the last count.
module lb_tick_gen
    import lb_key_events_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
    parameter int unsigned TICK_W   = TICK_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + TICK_W'(1);
        end
    end
endmodule

// File: rtl/lb_key_events.sv
// Switch level to press/release/auto-repeat pulses; auto-repeat exists only with LB_KEY_AUTOREPEAT_EN.
// state  | meaning
// IDLE   | switch released, waiting for press
// HOLD   | pressed, timing the initial hold delay
// REPEAT | held past the delay, pulsing at the repeat rate
module lb_key_events
    import lb_key_events_pkg::*;
`ifdef LB_KEY_AUTOREPEAT_EN
#(
    parameter int unsigned TICK_DIV   = TICK_DIV_DEFAULT,
    parameter int unsigned TICK_W     = TICK_W_DEFAULT,
    parameter int unsigned HOLD_TICKS = 50,
    parameter int unsigned RATE_TICKS = 10,
    parameter int unsigned CNT_W      = 8
)
`endif
(
    input  logic            clk,
    input  logic            reset,
    lb_key_events_if.slave  key
);
    key_state_e state_q, state_d;
    logic press_d, release_d, repeat_d;
    logic press_q, release_q, repeat_q, held_q;

`ifdef LB_KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(RATE_TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic tick, presc_clr;

    // Cleared on press so the hold delay is measured from the press itself.
    lb_tick_gen #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (presc_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;
`ifdef LB_KEY_AUTOREPEAT_EN
        cnt_d     = cnt_q;
        presc_clr = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (key.db_in) begin
                    state_d = HOLD;
                    press_d = 1'b1;
`ifdef LB_KEY_AUTOREPEAT_EN
                    presc_clr = 1'b1;
                    cnt_d     = '0;
`endif
                end
            end
            HOLD: begin
                if (!key.db_in) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end
`ifdef LB_KEY_AUTOREPEAT_EN
                else if (tick) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d  = REPEAT;
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`endif
            end
`ifdef LB_KEY_AUTOREPEAT_EN
            REPEAT: begin
                // Release beats a coincident tick; the count is simply dropped.
                if (!key.db_in) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end else if (tick) begin
                    if (cnt_q == RATE_LAST) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            held_q    <= (state_d != IDLE);
        end
    end

    assign key.press_pulse   = press_q;
    assign key.release_pulse = release_q;
    assign key.repeat_pulse  = repeat_q;
    assign key.held          = held_q;
endmodule

// File: tb/tb_lb_key_events.sv
// Self-checking bench for lb_key_events; expected pulses come from press-relative timing arithmetic.
module tb_lb_key_events;
    localparam int D = 4;
    localparam int H = 3;
    localparam int R = 2;
`ifdef LB_KEY_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    lb_key_events_if key();

    always #5 clk = ~clk;

`ifdef LB_KEY_AUTOREPEAT_EN
    lb_key_events #(
        .TICK_DIV   (D),
        .TICK_W     (3),
        .HOLD_TICKS (H),
        .RATE_TICKS (R),
        .CNT_W      (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .key   (key.slave)
    );
`else
    lb_key_events dut (
        .clk   (clk),
        .reset (reset),
        .key   (key.slave)
    );
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit m_held    = 1'b0;
    int m_press_t = 0;
    bit e_press, e_rel, e_rep;

    // One clock with db_in=d; model predicts outputs from time since the press.
    task automatic clk_step(input logic d);
        int el;
        key.db_in = d;
        @(posedge clk);
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_rep   = 1'b0;
        if (!m_held) begin
            if (d) begin
                m_held    = 1'b1;
                m_press_t = cyc;
                e_press   = 1'b1;
            end
        end else if (!d) begin
            m_held = 1'b0;
            e_rel  = 1'b1;
        end else if (AUTO) begin
            el = cyc - m_press_t;
            if (el >= H * D && ((el - H * D) % (R * D)) == 0) e_rep = 1'b1;
        end
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        m_held  = 1'b0;
        e_press = 1'b0;
        e_rel   = 1'b0;
        e_rep   = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        key.db_in = 1'b1;
        #2 reset = 1'b0;
        #1;
        got = {key.press_pulse, key.release_pulse, key.repeat_pulse, key.held};
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_async got=%b expected=0000", got);
        end
        repeat (3) @(posedge clk);
        #1;
        got = {key.press_pulse, key.release_pulse, key.repeat_pulse, key.held};
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_held_db got=%b expected=0000", got);
        end
        model_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            clk_step(i < 2);
            got = {key.press_pulse, key.release_pulse, key.repeat_pulse, key.held};
            n_checks++;
            if (got !== {e_press, e_rel, e_rep, m_held}) begin
                n_fail++;
                $display("FAIL reset_exit step=%0d got=%b expected=%b", i, got, {e_press, e_rel, e_rep, m_held});
            end
        end
    endtask

    task automatic test_hold_repeat();
        logic [3:0] got;
        int press_at, rel_at;
        int reps[$];
        press_at = -1;
        rel_at   = -1;
        for (int i = 0; i < 46; i++) begin
            clk_step(i < 40);
            got = {key.press_pulse, key.release_pulse, key.repeat_pulse, key.held};
            n_checks++;
            if (got !== {e_press, e_rel, e_rep, m_held}) begin
                n_fail++;
                $display("FAIL hold_repeat step=%0d got=%b expected=%b", i, got, {e_press, e_rel, e_rep, m_held});
            end
            if (key.press_pulse === 1'b1) press_at = i;
            if (key.release_pulse === 1'b1) rel_at = i;
            if (key.repeat_pulse === 1'b1) reps.push_back(i - press_at);
        end
        n_checks++;
        if (rel_at - press_at !== 40) begin
            n_fail++;
            $display("FAIL hold_release_latency got=%0d expected=40", rel_at - press_at);
        end
`ifdef LB_KEY_AUTOREPEAT_EN
        n_checks++;
        if (reps.size() !== 4 || reps[0] !== 12 || reps[1] !== 20 || reps[2] !== 28 || reps[3] !== 36) begin
            n_fail++;
            $display("FAIL repeat_times got=%p expected=12,20,28,36", reps);
        end
`else
        n_checks++;
        if (reps.size() !== 0) begin
            n_fail++;
            $display("FAIL repeat_disabled got=%0d pulses expected=0", reps.size());
        end
`endif
    endtask

    task automatic test_short_press();
        logic [3:0] got;
        int press_at, rel_at, nrep;
        press_at = -1;
        rel_at   = -1;
        nrep     = 0;
        for (int i = 0; i < 9; i++) begin
            clk_step(i < 5);
            got = {key.press_pulse, key.release_pulse, key.repeat_pulse, key.held};
            n_checks++;
            if (got !== {e_press, e_rel, e_rep, m_held}) begin
                n_fail++;
                $display("FAIL short_press step=%0d got=%b expected=%b", i, got, {e_press, e_rel, e_rep, m_held});
            end
            if (key.press_pulse === 1'b1) press_at = i;
            if (key.release_pulse === 1'b1) rel_at = i;
            if (key.repeat_pulse === 1'b1) nrep++;
        end
        n_checks++;
        if (rel_at - press_at !== 5 || nrep !== 0) begin
            n_fail++;
            $display("FAIL short_press_timing got gap=%0d reps=%0d expected gap=5 reps=0", rel_at - press_at, nrep);
        end
    endtask

    task automatic test_release_at_tick();
        logic [3:0] got;
        for (int i = 0; i < 15; i++) begin
            clk_step(i < 12);
            got = {key.press_pulse, key.release_pulse, key.repeat_pulse, key.held};
            n_checks++;
            if (got !== {e_press, e_rel, e_rep, m_held}) begin
                n_fail++;
                $display("FAIL release_at_tick step=%0d got=%b expected=%b", i, got, {e_press, e_rel, e_rep, m_held});
            end
            if (i == 12) begin
                n_checks++;
                if (got !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL release_wins got=%b expected=0100", got);
                end
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [3:0] got;
        int press_at;
        for (int i = 0; i < 9; i++) clk_step(1'b1);
        #2 reset = 1'b0;
        #1;
        got = {key.press_pulse, key.release_pulse, key.repeat_pulse, key.held};
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_hold_reset_async got=%b expected=0000", got);
        end
        repeat (2) @(posedge clk);
        #1;
        got = {key.press_pulse, key.release_pulse, key.repeat_pulse, key.held};
        n_checks++;
        if (got !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_hold_no_release got=%b expected=0000", got);
        end
        model_reset();
        reset = 1'b1;
        press_at = -1;
        for (int i = 0; i < 18; i++) begin
            clk_step(i < 16);
            got = {key.press_pulse, key.release_pulse, key.repeat_pulse, key.held};
            n_checks++;
            if (got !== {e_press, e_rel, e_rep, m_held}) begin
                n_fail++;
                $display("FAIL mid_hold_restart step=%0d got=%b expected=%b", i, got, {e_press, e_rel, e_rep, m_held});
            end
            if (key.press_pulse === 1'b1) press_at = i;
        end
        n_checks++;
        if (press_at !== 0) begin
            n_fail++;
            $display("FAIL mid_hold_fresh_press got step=%0d expected step=0", press_at);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] got;
        logic [9:0] pat;
        pat = 10'b0011010101;
        for (int i = 0; i < 10; i++) begin
            clk_step(pat[i]);
            got = {key.press_pulse, key.release_pulse, key.repeat_pulse, key.held};
            n_checks++;
            if (got !== {e_press, e_rel, e_rep, m_held}) begin
                n_fail++;
                $display("FAIL back_to_back step=%0d got=%b expected=%b", i, got, {e_press, e_rel, e_rep, m_held});
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] got;
        logic d;
        int run;
        d   = 1'b0;
        run = 0;
        for (int i = 0; i < 600; i++) begin
            if (run == 0) begin
                d   = ~d;
                run = $urandom_range(1, 30);
            end
            run--;
            clk_step(d);
            got = {key.press_pulse, key.release_pulse, key.repeat_pulse, key.held};
            n_checks++;
            if (got !== {e_press, e_rel, e_rep, m_held}) begin
                n_fail++;
                $display("FAIL random step=%0d got=%b expected=%b", i, got, {e_press, e_rel, e_rep, m_held});
            end
        end
    endtask

    initial begin
        key.db_in = 1'b0;
        test_reset();
        test_hold_repeat();
        test_short_press();
        test_release_at_tick();
        test_reset_mid_hold();
        test_back_to_back();
        for (int i = 0; i < 3; i++) clk_step(1'b0);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
